// File: rtl/seq_ctrl_pkg.sv
// Shared types, sequence constants and helpers for the 0->6->1->4->3 run controller.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [2:0] S0      = 3'd0;
  localparam logic [2:0] S6      = 3'd6;
  localparam logic [2:0] S1      = 3'd1;
  localparam logic [2:0] S4      = 3'd4;
  localparam logic [2:0] S3      = 3'd3;
  localparam logic [2:0] RECOVER = 3'd1;

  function automatic logic [2:0] next_seq(input logic [2:0] s);
    logic [2:0] n;
    case (s)
      S0:      n = S6;
      S6:      n = S1;
      S1:      n = S4;
      S4:      n = S3;
      S3:      n = S0;
      default: n = RECOVER;
    endcase
    return n;
  endfunction

  function automatic logic is_legal(input logic [2:0] s);
    return (s == S0) || (s == S6) || (s == S1) || (s == S4) || (s == S3);
  endfunction

endpackage

// File: rtl/seq_step_core.sv
// Sequence state register: advances on step, loads on load, flags the 3->0 wrap.
module seq_step_core
  import seq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic [2:0] state,
  output logic       wrap
);

  always_ff @(posedge clk) begin
    if (rst)       state <= S0;
    else if (load) state <= load_val;
    else if (step) state <= next_seq(state);
  end

  assign wrap = step && (state == S3);

endmodule

// File: rtl/seq_run_ctrl.sv
// Run controller: continuous / burst / single-step advance of the sequence at a programmable period.
//   state   | meaning
//   IDLE    | waiting; accepts stop > start > single_step > seed_load
//   RUN     | stepping every period+1 cycles until stop or burst end
//   STEP    | one manual step, then IDLE
//   DONE    | one-cycle done pulse, then IDLE
module seq_run_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int PRESCALE_W = 8,
  parameter int CYCLES_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  single_step,
  input  logic                  mode,
  input  logic [PRESCALE_W-1:0] period,
  input  logic [CYCLES_W-1:0]   n_cycles,
  input  logic                  seed_load,
  input  logic [2:0]            seed,
  output logic [2:0]            count,
  output logic                  step_pulse,
  output logic                  busy,
  output logic                  done,
  output logic [CYCLES_W-1:0]   cycle_cnt,
  output logic                  err
);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] period_q, presc_q;
  logic [CYCLES_W-1:0]   n_q, cycle_q, cycle_next;
  logic                  mode_q, err_q;
  logic                  idle_start, seed_acc, wrap, burst_end;

  assign idle_start = (state_q == ST_IDLE) && !stop && start;
  assign seed_acc   = (state_q == ST_IDLE) && !stop && !start && !single_step && seed_load;
  assign cycle_next = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
  assign burst_end  = mode_q && wrap && (cycle_next == n_q);

  seq_step_core u_core (
    .clk      (clk),
    .rst      (rst),
    .step     (step_pulse),
    .load     (seed_acc),
    .load_val (seed),
    .state    (count),
    .wrap     (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!stop) begin
          if (start)            state_d = (mode && (n_cycles == '0)) ? ST_DONE : ST_RUN;
          else if (single_step) state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (stop)           state_d = ST_IDLE;
        else if (burst_end) state_d = ST_DONE;
      end
      ST_STEP: state_d = ST_IDLE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are held low while rst is asserted, whatever the state register holds.
  always_comb begin
    step_pulse = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          busy       = 1'b1;
          step_pulse = !stop && (presc_q == period_q);
        end
        ST_STEP: begin
          busy       = 1'b1;
          step_pulse = 1'b1;
        end
        ST_DONE: done = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
      n_q      <= '0;
      mode_q   <= 1'b0;
      presc_q  <= '0;
      cycle_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (idle_start) begin
        period_q <= period;
        n_q      <= n_cycles;
        mode_q   <= mode;
        presc_q  <= '0;
        cycle_q  <= '0;
      end
      if ((state_q == ST_RUN) && !stop)
        presc_q <= step_pulse ? '0 : presc_q + 1'b1;
      if (wrap)
        cycle_q <= cycle_next;
      if (step_pulse && !is_legal(count))
        err_q <= 1'b1;
      if (seed_acc)
        err_q <= !is_legal(seed);
    end
  end

  assign cycle_cnt = cycle_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic vs a behavioural model.
module tb_seq_run_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, single_step = 1'b0, mode = 1'b0;
  logic [7:0] period = 8'd0;
  logic [3:0] n_cycles = 4'd0;
  logic       seed_load = 1'b0;
  logic [2:0] seed = 3'd0;
  logic [2:0] count;
  logic       step_pulse, busy, done, err;
  logic [3:0] cycle_cnt;

  int checks = 0;
  int failures = 0;

  seq_run_ctrl #(.PRESCALE_W(8), .CYCLES_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .single_step(single_step),
    .mode(mode), .period(period), .n_cycles(n_cycles), .seed_load(seed_load),
    .seed(seed), .count(count), .step_pulse(step_pulse), .busy(busy), .done(done),
    .cycle_cnt(cycle_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: successor table, edges-until-next-step countdown, wrap tally.
  int  succ [0:7] = '{6, 4, 1, 0, 3, 1, 1, 1};
  int  m_count = 0, m_wraps = 0, m_target = 0, m_per = 0, m_left = 0;
  bit  m_err = 0, m_run = 0, m_stp = 0, m_done = 0, m_burst = 0;
  bit  chk_en = 0;

  function automatic bit exp_step();
    return !rst && ((m_run && (m_left == 1) && !stop) || m_stp);
  endfunction

  task automatic model_edge();
    bit sp, wrapped;
    if (rst) begin
      m_count = 0; m_wraps = 0; m_err = 0;
      m_run = 0; m_stp = 0; m_done = 0;
      return;
    end
    sp = exp_step();
    wrapped = 0;
    if (sp) begin
      if (m_count == 2 || m_count == 5 || m_count == 7) m_err = 1;
      if (m_count == 3) begin
        wrapped = 1;
        if (m_wraps < 15) m_wraps++;
      end
      m_count = succ[m_count];
    end
    if (m_done) m_done = 0;
    else if (m_stp) m_stp = 0;
    else if (m_run) begin
      if (stop) m_run = 0;
      else if (sp) begin
        m_left = m_per + 1;
        if (m_burst && wrapped && m_wraps == m_target) begin
          m_run = 0;
          m_done = 1;
        end
      end else m_left--;
    end else if (!stop) begin
      if (start) begin
        m_per = period; m_target = n_cycles; m_burst = mode; m_wraps = 0;
        if (mode && n_cycles == 0) m_done = 1;
        else begin m_run = 1; m_left = m_per + 1; end
      end else if (single_step) m_stp = 1;
      else if (seed_load) begin
        m_count = seed;
        m_err = (seed == 2 || seed == 5 || seed == 7);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
    chk_en = 1;
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("model_count", count, m_count);
      chk("model_step_pulse", step_pulse, exp_step());
      chk("model_busy", busy, !rst && (m_run || m_stp));
      chk("model_done", done, !rst && m_done);
      chk("model_cycle_cnt", cycle_cnt, m_wraps);
      chk("model_err", err, m_err);
    end
  end

  int exp6 [0:5] = '{6, 1, 4, 3, 0, 6};
  int nstep, ndone;

  initial begin
    // Reset, then idle
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_step_pulse", step_pulse, 0);
    end
    chk("reset_count", count, 0);
    chk("reset_err", err, 0);
    chk("reset_busy", busy, 0);

    // Continuous, period 0
    mode = 0; period = 0; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("cont_p0_count", count, exp6[i]);
      if (i == 4) chk("cont_p0_wrap", cycle_cnt, 1);
    end
    stop = 1; tick(); stop = 0;

    // Burst of 2 cycles at period 2 from a zero seed
    seed = 0; seed_load = 1; tick(); seed_load = 0;
    mode = 1; n_cycles = 2; period = 2; start = 1;
    tick();
    start = 0;
    nstep = 0; ndone = 0;
    for (int c = 0; c < 100 && ndone == 0; c++) begin
      if (step_pulse) nstep++;
      if (done) begin
        ndone++;
        chk("burst_steps", nstep, 10);
        chk("burst_count", count, 0);
        chk("burst_cycle_cnt", cycle_cnt, 2);
      end else tick();
    end
    chk("burst_done_seen", ndone, 1);
    tick();
    chk("burst_busy_after", busy, 0);
    chk("burst_done_once", done, 0);
    chk("burst_count_hold", count, 0);

    // Stop on the cycle a step would fire
    seed = 6; seed_load = 1; tick(); seed_load = 0;
    mode = 0; period = 3; start = 1;
    tick();
    start = 0;
    repeat (3) tick();
    stop = 1; #1;
    chk("stop_suppress_step", step_pulse, 0);
    tick();
    stop = 0;
    chk("stop_busy", busy, 0);
    chk("stop_count", count, 6);
    start = 1; stop = 1; tick();
    chk("start_stop_idle", busy, 0);
    start = 0; stop = 0;

    // Illegal seed, single step, legal reseed
    seed = 5; seed_load = 1; tick(); seed_load = 0;
    chk("seed5_count", count, 5);
    chk("seed5_err", err, 1);
    single_step = 1; tick(); single_step = 0;
    chk("single_busy", busy, 1);
    chk("single_pulse", step_pulse, 1);
    tick();
    chk("single_count", count, 1);
    chk("single_err_sticky", err, 1);
    chk("single_busy_end", busy, 0);
    seed = 4; seed_load = 1; tick(); seed_load = 0;
    chk("seed4_err", err, 0);

    // Zero-length burst, then reset mid-burst
    mode = 1; n_cycles = 0; start = 1; tick(); start = 0;
    chk("zero_burst_done", done, 1);
    chk("zero_burst_pulse", step_pulse, 0);
    tick();
    chk("zero_burst_done_end", done, 0);
    chk("zero_burst_count", count, 4);
    n_cycles = 3; period = 1; start = 1; tick(); start = 0;
    repeat (7) tick();
    rst = 1; tick();
    chk("midrst_count", count, 0);
    chk("midrst_cycle_cnt", cycle_cnt, 0);
    chk("midrst_done", done, 0);
    rst = 0;
    repeat (5) begin
      tick();
      chk("post_rst_done", done, 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      start       = ($urandom_range(0, 9) == 0);
      stop        = ($urandom_range(0, 29) == 0);
      single_step = ($urandom_range(0, 9) == 0);
      seed_load   = ($urandom_range(0, 4) == 0);
      seed        = 3'($urandom_range(0, 7));
      mode        = 1'($urandom_range(0, 1));
      period      = 8'($urandom_range(0, 3));
      n_cycles    = 4'($urandom_range(0, 3));
      tick();
    end
    rst = 0; start = 0; stop = 0; single_step = 0; seed_load = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
